// File: rtl/drm_stream_pkg.sv
// Shared geometry and pointer/count types for the drm_8x1024 stream FIFO.
package drm_stream_pkg;

  localparam int DRM_DATA_WIDTH = 8;
  localparam int DRM_ADDR_WIDTH = 10;
  localparam int DRM_DEPTH      = 2 ** DRM_ADDR_WIDTH;
  localparam int DRM_PTR_WIDTH  = DRM_ADDR_WIDTH + 1;
  localparam int DRM_CNT_WIDTH  = DRM_ADDR_WIDTH + 2;

  typedef logic [DRM_PTR_WIDTH-1:0] ptr_t;
  typedef logic [DRM_CNT_WIDTH-1:0] count_t;

endpackage

// File: rtl/drm_8x1024.sv
// Simple dual-port 8x1024 DRM core: byte-enabled write port, 1-cycle registered read port.
module drm_8x1024 (
  input  logic       wr_clk,
  input  logic       wr_rst,
  input  logic       wr_en,
  input  logic [0:0] wr_byte_en,
  input  logic [9:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       rd_clk,
  input  logic       rd_rst,
  input  logic [9:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [1024];

  // NOTE: the array has no reset branch; clearing it would turn block RAM into a huge flop bank.
  always_ff @(posedge wr_clk) begin
    if (!wr_rst && wr_en && wr_byte_en[0]) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) rd_data <= '0;
    else        rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/drm_out_skid.sv
// Two-entry output queue (head + skid) that absorbs RAM read data and feeds the consumer.
module drm_out_skid #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  pop,
  output logic [1:0]            out_cnt
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  pop_eff;
  logic [1:0]            cnt_next;

  // NOTE: every always_comb output gets an unconditional assignment so no latch can form.
  always_comb begin
    pop_eff  = pop && (out_cnt != 2'd0);
    cnt_next = out_cnt + 2'(in_valid) - 2'(pop_eff);
  end

  // NOTE: registered state uses <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt   <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid_data <= '0;
    end else begin
      out_cnt   <= cnt_next;
      out_valid <= (cnt_next != 2'd0);
      // Head only moves on pop or when filling an empty queue, so it is stable during stalls.
      if (pop_eff && out_cnt == 2'd2)                  out_data <= skid_data;
      else if (in_valid && (pop_eff || out_cnt == 2'd0)) out_data <= in_data;
      if (in_valid && ((out_cnt == 2'd1 && !pop_eff) || (out_cnt == 2'd2 && pop_eff)))
        skid_data <= in_data;
    end
  end

endmodule

// File: rtl/drm_stream_fifo.sv
// FWFT valid/ready FIFO around drm_8x1024: pointer management, read issue, and output buffering.
module drm_stream_fifo
  import drm_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DRM_DATA_WIDTH,
  parameter int ADDR_WIDTH = DRM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ADDR_WIDTH+1:0] count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  ptr_t                  ram_cnt;
  count_t                count_q;
  logic                  inflight;
  logic [1:0]            out_cnt;
  logic [2:0]            out_pending;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  push;
  logic                  pop;
  logic                  issue;

  assign ram_cnt = wr_ptr - rd_ptr;
  assign s_ready = !rst && (ram_cnt != ptr_t'(DEPTH));
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;
  assign count   = count_q;

  // Issue only when the word is guaranteed a slot in the 2-entry output queue next cycle.
  always_comb begin
    out_pending = 3'(out_cnt) + 3'(inflight) - 3'(pop);
    issue       = (ram_cnt != '0) && (out_pending < 3'd2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
      count_q  <= '0;
    end else begin
      wr_ptr   <= wr_ptr + ptr_t'(push);
      rd_ptr   <= rd_ptr + ptr_t'(issue);
      inflight <= issue;
      count_q  <= count_q + count_t'(push) - count_t'(pop);
    end
  end

  drm_8x1024 u_ram (
    .wr_clk     (clk),
    .wr_rst     (rst),
    .wr_en      (push),
    .wr_byte_en ('1),
    .wr_addr    (wr_ptr[ADDR_WIDTH-1:0]),
    .wr_data    (s_data),
    .rd_clk     (clk),
    .rd_rst     (rst),
    .rd_addr    (rd_ptr[ADDR_WIDTH-1:0]),
    .rd_data    (rd_data)
  );

  drm_out_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (inflight),
    .in_data   (rd_data),
    .out_valid (m_valid),
    .out_data  (m_data),
    .pop       (pop),
    .out_cnt   (out_cnt)
  );

endmodule

// File: tb/tb_drm_stream_fifo.sv
// Self-checking bench for drm_stream_fifo: queue-based model, per-cycle compare, directed + random traffic.
module tb_drm_stream_fifo;

  localparam int DEPTH = 1024;
  localparam int MAXW  = 1026;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [11:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] q [$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = '0;

  drm_stream_fifo dut (
    .clk     (clk),
    .rst     (rst),
    .s_data  (s_data),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .m_data  (m_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Model: every accepted word joins the queue; every consumed word leaves its front.
  always @(posedge clk) begin
    if (rst) q.delete();
    else begin
      if (m_valid && m_ready && q.size() > 0) void'(q.pop_front());
      if (s_valid && s_ready) q.push_back(s_data);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("s_ready_in_reset", 32'(s_ready), 32'd0);
      prev_stall = 1'b0;
    end else begin
      check("count", 32'(count), 32'(q.size()));
      if (q.size() == 0) check("m_valid_when_empty", 32'(m_valid), 32'd0);
      else if (m_valid)  check("m_data_order", 32'(m_data), 32'(q[0]));
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 32'd1);
        check("stall_data", 32'(m_data), 32'(prev_data));
      end
      if (q.size() == MAXW)      check("s_ready_full", 32'(s_ready), 32'd0);
      else if (q.size() < DEPTH) check("s_ready_space", 32'(s_ready), 32'd1);
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
  endtask

  task automatic drain();
    next_cycle();
    s_valid = 1'b0; m_ready = 1'b1;
    for (int k = 0; k < 1200; k++) begin
      if (q.size() == 0 && !m_valid) break;
      next_cycle();
    end
    check("drain_empty", 32'(q.size()), 32'd0);
    m_ready = 1'b0;
  endtask

  initial begin
    int accepted;
    int idle;
    int pushed;

    do_reset();

    // Latency: first word visible three cycles after it is pushed.
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      s_valid = 1'b1; s_data = 8'(i);
      @(negedge clk);
      if (i == 2) check("latency_not_yet", 32'(m_valid), 32'd0);
      if (i == 3) begin
        check("latency_valid", 32'(m_valid), 32'd1);
        check("latency_first_data", 32'(m_data), 32'h00);
      end
    end
    next_cycle();
    s_valid = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    check("count_after_10", 32'(count), 32'd10);

    // Fill to capacity with the consumer stalled.
    do_reset();
    accepted = 0; idle = 0;
    next_cycle();
    s_valid = 1'b1;
    for (int i = 0; i < 1100 && idle < 5; i++) begin
      s_data = 8'(accepted);
      @(negedge clk);
      if (s_ready) accepted++;
      else idle++;
      next_cycle();
    end
    check("fill_accepted", 32'(accepted), 32'd1026);
    @(negedge clk);
    check("full_count", 32'(count), 32'd1026);
    check("full_s_ready", 32'(s_ready), 32'd0);

    // Single pop while full: space reappears within two cycles.
    next_cycle();
    s_valid = 1'b0; m_ready = 1'b1;
    next_cycle();
    m_ready = 1'b0;
    @(negedge clk);
    check("pop_count", 32'(count), 32'd1025);
    next_cycle();
    @(negedge clk);
    check("pop_s_ready_back", 32'(s_ready), 32'd1);
    next_cycle();
    s_valid = 1'b1;
    @(negedge clk);
    check("held_word_accept", 32'(s_ready), 32'd1);
    drain();

    // Sustained streaming across pointer wrap.
    next_cycle();
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      s_data = 8'(255 - i);
      @(negedge clk);
      check("stream_no_bubble", 32'(m_valid), 32'(i >= 3));
      next_cycle();
    end
    drain();

    // Random handshakes on both sides.
    pushed = 0;
    for (int c = 0; c < 40000 && pushed < 5000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      m_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (s_valid && s_ready) pushed++;
      next_cycle();
    end
    check("random_pushed", 32'(pushed), 32'd5000);
    drain();

    // Reset mid-occupancy: nothing stale may come out afterwards.
    accepted = 0;
    s_valid = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 600 && accepted < 500; i++) begin
      s_data = 8'($urandom);
      @(negedge clk);
      if (s_ready) accepted++;
      next_cycle();
    end
    s_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_count", 32'(count), 32'd500);
    do_reset();
    next_cycle();
    s_valid = 1'b1; s_data = 8'hA5;
    next_cycle();
    s_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (m_valid) break;
      next_cycle();
    end
    check("post_reset_valid", 32'(m_valid), 32'd1);
    check("post_reset_data", 32'(m_data), 32'hA5);
    next_cycle();
    m_ready = 1'b1;
    next_cycle();
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("no_stale_word", 32'(m_valid), 32'd0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
